// File: rtl/load_store_unit.sv
// RV32I memory stage: validates, issues and completes one load/store per instruction over a req/ack bus.
// Optional access timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [2:0]              Funct3,
    input  logic [DATA_WIDTH-1:0]   ALUResult,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic                    Flush,
    output logic                    MemReq,
    output logic                    MemWe,
    output logic [DATA_WIDTH-1:0]   MemAddr,
    output logic [DATA_WIDTH-1:0]   MemWData,
    output logic [3:0]              MemByteEn,
    input  logic [DATA_WIDTH-1:0]   MemRData,
    input  logic                    MemAck,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    LoadDone,
    output logic                    Stall,
    output logic                    AccessFault
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    function automatic logic f_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else begin
            case (f3)
                3'b000:  ok = 1'b1;
                3'b001:  ok = (off[0] == 1'b0);
                3'b010:  ok = (off == 2'b00);
                3'b100:  ok = rd;
                3'b101:  ok = rd && (off[0] == 1'b0);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] wd);
        logic [31:0] d;
        if (f3[1:0] == 2'b10) begin
            d = wd;
        end else begin
            d = wd << {off, 3'b000};
        end
        return d;
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] lane;
        logic [31:0] res;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b100:  res = {24'h000000, lane[7:0]};
            3'b101:  res = {16'h0000, lane[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    state_t      r_state, w_next;
    logic        w_start, w_fault, w_ack_done, w_timeout, w_timeout_hit, w_legal;
    logic        r_mem_req, r_mem_we, r_load_done, r_fault, r_is_load, r_discard;
    logic [31:0] r_mem_addr, r_mem_wdata, r_read_data;
    logic [3:0]  r_byte_en;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;

    assign w_legal = f_legal(MemRead, MemWrite, Funct3, ALUResult[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counts ACCESS cycles since the request was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state and control decode.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_fault    = 1'b0;
        w_ack_done = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((MemRead || MemWrite) && !Flush) begin
                    if (w_legal) begin
                        w_start = 1'b1;
                        w_next  = S_ACCESS;
                    end else begin
                        w_fault = 1'b1;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (MemAck) begin
                    w_ack_done = 1'b1;
                    w_next     = S_DONE;
                end else if (w_timeout_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_next = S_ACCESS;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall covers the start cycle combinationally so upstream freezes immediately.
    assign Stall = w_start || (r_state == S_ACCESS);

    // State, bus request fields and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_byte_en   <= 4'h0;
            r_read_data <= 32'h0;
            r_load_done <= 1'b0;
            r_fault     <= 1'b0;
            r_is_load   <= 1'b0;
            r_discard   <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
        end else begin
            r_state     <= w_next;
            r_load_done <= 1'b0;
            r_fault     <= w_fault || w_timeout;
            if (w_start) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= MemWrite;
                r_mem_addr  <= {ALUResult[31:2], 2'b00};
                r_byte_en   <= f_byte_en(Funct3, ALUResult[1:0]);
                r_mem_wdata <= f_wdata(Funct3, ALUResult[1:0], WriteData);
                r_f3        <= Funct3;
                r_off       <= ALUResult[1:0];
                r_is_load   <= MemRead;
                r_discard   <= 1'b0;
            end else if (r_state == S_ACCESS && Flush) begin
                r_discard <= 1'b1;
            end else begin
                r_discard <= r_discard;
            end
            if (w_ack_done || w_timeout) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            // A flush arriving in the ack cycle still discards the result.
            if (w_ack_done && r_is_load && !r_discard && !Flush) begin
                r_read_data <= f_extend(r_f3, r_off, MemRData);
                r_load_done <= 1'b1;
            end
        end
    end

    assign MemReq      = r_mem_req;
    assign MemWe       = r_mem_we;
    assign MemAddr     = r_mem_addr;
    assign MemWData    = r_mem_wdata;
    assign MemByteEn   = r_byte_en;
    assign ReadData    = r_read_data;
    assign LoadDone    = r_load_done;
    assign AccessFault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized transactions
// against an arithmetic reference model, and reset/idle-ack/timeout sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, Flush, MemAck;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData, MemRData;
    logic        MemReq, MemWe, LoadDone, Stall, AccessFault;
    logic [31:0] MemAddr, MemWData, ReadData;
    logic [3:0]  MemByteEn;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] last_rd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          dly;
        logic [1:0]  fl;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_ld;
    } vec_t;

    vec_t tbl[16];

    load_store_unit dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .Flush(Flush), .MemReq(MemReq),
        .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn),
        .MemRData(MemRData), .MemAck(MemAck), .ReadData(ReadData), .LoadDone(LoadDone),
        .Stall(Stall), .AccessFault(AccessFault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built from the access rules using plain arithmetic.
    function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rdata, input int dly, input logic [1:0] fl);
        vec_t v;
        int size, off;
        logic legal;
        logic [31:0] mask, val;
        off  = int'(addr[1:0]);
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        if (rd && wr)  legal = 1'b0;
        else if (rd)   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else           legal = (f3 inside {3'd0, 3'd1, 3'd2});
        if (off % size != 0) legal = 1'b0;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        val  = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.dly = dly; v.fl = fl;
        v.exp_fault = !legal && (fl != 2'd1);
        v.exp_be    = 4'(((1 << size) - 1) << off);
        v.exp_wd    = wd << (8 * off);
        v.exp_rd    = val;
        v.exp_ld    = legal && rd && (fl == 2'd0);
        return v;
    endfunction

    task automatic clear_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b0; MemAck = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int stalls;
        logic start;
        start = !v.exp_fault && (v.fl != 2'd1);
        @(negedge clk);
        MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3; ALUResult = v.addr;
        WriteData = v.wd; Flush = (v.fl == 2'd1);
        #1;
        check("stall_start", 32'(Stall), 32'(start));
        stalls = Stall ? 1 : 0;
        @(negedge clk);
        if (!start) begin
            check("fault_pulse", 32'(AccessFault), 32'(v.exp_fault));
            check("no_req", 32'(MemReq), 32'h0);
            check("no_stall", 32'(Stall), 32'h0);
            clear_inputs();
            @(negedge clk);
            check("fault_once", 32'(AccessFault), 32'h0);
            return;
        end
        check("req", 32'(MemReq), 32'h1);
        check("we", 32'(MemWe), 32'(v.wr));
        check("addr", MemAddr, {v.addr[31:2], 2'b00});
        check("byte_en", 32'(MemByteEn), 32'(v.exp_be));
        if (v.wr) check("wdata", MemWData, v.exp_wd);
        clear_inputs();
        ALUResult = $urandom; WriteData = $urandom; Funct3 = 3'($urandom);
        for (int c = 0; c <= v.dly; c++) begin
            MemAck   = (c == v.dly);
            MemRData = (c == v.dly) ? v.rdata : $urandom;
            Flush    = (v.fl == 2'd2) && (c == 0);
            #1;
            if (Stall) stalls++;
            if (c == v.dly) begin
                check("req_held", 32'(MemReq), 32'h1);
                check("addr_held", MemAddr, {v.addr[31:2], 2'b00});
            end
            @(negedge clk);
        end
        MemAck = 1'b0; Flush = 1'b0;
        if (v.exp_ld) last_rd = v.exp_rd;
        check("done_req", 32'(MemReq), 32'h0);
        check("done_stall", 32'(Stall), 32'h0);
        check("load_done", 32'(LoadDone), 32'(v.exp_ld));
        check("read_data", ReadData, last_rd);
        check("stall_cycles", 32'(stalls), 32'(v.dly + 2));
        @(negedge clk);
        check("load_done_once", 32'(LoadDone), 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 2'd0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 2'd0, 1'b0, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 2'd0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b101, 32'h4000, 32'h0, 32'h0000_9ABC, 4, 2'd0, 1'b0, 4'b0011, 32'h0, 32'h0000_9ABC, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h1234_5678, 2, 2'd2, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h6002, 32'h0, 32'h8001_0000, 1, 2'd0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h7001, 32'h0, 32'h0000_AB00, 0, 2'd0, 1'b0, 4'b0010, 32'h0, 32'h0000_00AB, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 3'b000, 32'h8002, 32'h0000_00CC, 32'h0, 0, 2'd0, 1'b0, 4'b0100, 32'h00CC_0000, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h9000, 32'hDEAD_BEEF, 32'h0, 1, 2'd0, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'b010, 32'h0100, 32'h0, 32'h0, 0, 2'd0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h0100, 32'h0, 32'h0, 0, 2'd0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 3'b100, 32'h0104, 32'h0, 32'h0, 0, 2'd0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 3'b001, 32'h2001, 32'h0, 32'h0, 0, 2'd0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 2'd1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 3'b010, 32'hA004, 32'h0, 32'hCAFE_F00D, 3, 2'd0, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 3'b000, 32'hB000, 32'h0, 32'h0000_007F, 0, 2'd0, 1'b0, 4'b0001, 32'h0, 32'h0000_007F, 1'b1};

        rst = 1'b1; clear_inputs();
        Funct3 = 3'b000; ALUResult = 32'h0; WriteData = 32'h0; MemRData = 32'h0;
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(MemReq), 32'h0);
        check("rst_we", 32'(MemWe), 32'h0);
        check("rst_be", 32'(MemByteEn), 32'h0);
        check("rst_addr", MemAddr, 32'h0);
        check("rst_wdata", MemWData, 32'h0);
        check("rst_rdata", ReadData, 32'h0);
        check("rst_ld", 32'(LoadDone), 32'h0);
        check("rst_fault", 32'(AccessFault), 32'h0);
        check("rst_stall", 32'(Stall), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) do_txn(tbl[i]);

        // Acknowledge outside ACCESS must be ignored.
        @(negedge clk);
        MemAck = 1'b1; MemRData = 32'h5555_AAAA;
        @(negedge clk);
        check("idle_ack_ld", 32'(LoadDone), 32'h0);
        check("idle_ack_req", 32'(MemReq), 32'h0);
        check("idle_ack_rd", ReadData, last_rd);
        MemAck = 1'b0;

        for (int i = 0; i < 60; i++) begin
            int kind;
            logic rd, wr;
            logic [1:0] fl;
            kind = $urandom_range(0, 9);
            rd = (kind <= 5);
            wr = (kind == 0) || (kind >= 6);
            fl = ($urandom_range(0, 7) == 0) ? 2'd1 : (($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0);
            do_txn(model(rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
                         $urandom_range(0, 3), fl));
        end

        // Reset during ACCESS abandons the request asynchronously.
        @(negedge clk);
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0200;
        @(negedge clk);
        clear_inputs();
        check("pre_rst_req", 32'(MemReq), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(MemReq), 32'h0);
        check("async_rst_stall", 32'(Stall), 32'h0);
        check("async_rst_rd", ReadData, 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        do_txn(tbl[0]);

`ifdef LSU_TIMEOUT_EN
        begin
            int acc, guard;
            acc = 0; guard = 0;
            @(negedge clk);
            MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0300;
            @(negedge clk);
            clear_inputs();
            while (!AccessFault && guard < 40) begin
                if (MemReq) acc++;
                @(negedge clk);
                guard++;
            end
            check("to_fault", 32'(AccessFault), 32'h1);
            check("to_cycles", 32'(acc), 32'd16);
            check("to_stall", 32'(Stall), 32'h0);
            check("to_req", 32'(MemReq), 32'h0);
            check("to_ld", 32'(LoadDone), 32'h0);
            check("to_rd", ReadData, last_rd);
            @(negedge clk);
            check("to_fault_once", 32'(AccessFault), 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
